// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD combinational reads, two prioritised writes, busy scoreboard.
// Latency: reads 0 cycles; writes and busy updates land on the edge; clear sweep takes NREGS cycles.
// Backpressure: none; writes and reservations are silently dropped while ready is low.
module regfile_mp #(
  parameter int RADDRWIDTH = 3,
  parameter int REGWIDTH   = 16,
  parameter int NREAD      = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          ready,
  input  logic [NREAD*RADDRWIDTH-1:0]   raddr,
  output logic [NREAD*REGWIDTH-1:0]     rdata,
  output logic [NREAD-1:0]              rbusy,
  input  logic                          we0,
  input  logic [RADDRWIDTH-1:0]         waddr0,
  input  logic [REGWIDTH-1:0]           wdata0,
  input  logic                          we1,
  input  logic [RADDRWIDTH-1:0]         waddr1,
  input  logic [REGWIDTH-1:0]           wdata1,
  input  logic                          resv,
  input  logic [RADDRWIDTH-1:0]         resv_addr,
  output logic [(2**RADDRWIDTH)-1:0]    busy
);

  localparam int NREGS = 2**RADDRWIDTH;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state, state_nxt;
  logic [RADDRWIDTH-1:0]   cnt, cnt_nxt;
  logic [REGWIDTH-1:0]     mem [NREGS];
  logic [NREGS-1:0]        busy_q, busy_nxt;
  logic                    wr0_ok, wr1_ok;

  // ready comes straight off the state flop, so rst has no combinational path to it
  assign ready = (state == ST_RUN);
  assign busy  = busy_q;

  // writes to the hardwired zero register are dropped before they reach storage
  assign wr0_ok = ready && we0 && !((ZERO_REG != 0) && (waddr0 == '0));
  assign wr1_ok = ready && we1 && !((ZERO_REG != 0) && (waddr1 == '0));

  // state, sweep counter and scoreboard registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_INIT;
      cnt    <= '0;
      busy_q <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      busy_q <= busy_nxt;
    end
  end

  // sweep sequencing: step through every entry once, then enter RUN
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == ST_INIT) begin
      cnt_nxt = cnt + 1'b1;
      if (cnt == RADDRWIDTH'(NREGS - 1)) begin
        state_nxt = ST_RUN;
      end
    end
  end

  // scoreboard update: writes retire a producer, a reservation (applied last) marks a new one
  always_comb begin
    busy_nxt = busy_q;
    if (ready) begin
      if (we0)  busy_nxt[waddr0]    = 1'b0;
      if (we1)  busy_nxt[waddr1]    = 1'b0;
      if (resv) busy_nxt[resv_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      busy_nxt[0] = 1'b0;
    end
  end

  // storage: sweep clear during INIT; in RUN port 1 is written last so it wins collisions
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        mem[cnt] <= '0;
      end else begin
        if (wr0_ok) mem[waddr0] <= wdata0;
        if (wr1_ok) mem[waddr1] <= wdata1;
      end
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [RADDRWIDTH-1:0] ra;
    logic [REGWIDTH-1:0]   rd;
    logic                  rb;

    assign ra = raddr[k*RADDRWIDTH +: RADDRWIDTH];

    // read mux: zero register, then same-cycle write data (port 1 first), then storage
    always_comb begin
      rd = '0;
      rb = 1'b0;
      if (ready) begin
        rb = busy_q[ra];
        if ((ZERO_REG != 0) && (ra == '0)) begin
          rd = '0;
        end else if ((BYPASS != 0) && we1 && (waddr1 == ra)) begin
          rd = wdata1;
        end else if ((BYPASS != 0) && we0 && (waddr0 == ra)) begin
          rd = wdata0;
        end else begin
          rd = mem[ra];
        end
      end
    end

    assign rdata[k*REGWIDTH +: REGWIDTH] = rd;
    assign rbusy[k]                      = rb;
  end

endmodule
